// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous-read font ROM between the title
// renderer (port 0) and the score renderer (port 1). Grants are combinational,
// one lookup per cycle, and the row comes back two edges after the transfer
// together with a one-cycle valid pulse for the requester that asked for it.
module font_rom_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_add,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] data_out,
  output logic              valid0,
  output logic              valid1
);

  // last_grant: requester of the most recent transfer (resets to 1 so that
  // port 0 wins the first tie in round-robin mode)
  logic last_grant;
  // stage tags: s1 lines up with rom_add, s2 lines up with rom_data
  logic s1_v, s1_id;
  logic s2_v, s2_id;
  logic tie0;
  logic xfer;
  logic xfer_id;

  // Grant decode: a tie goes to port 0 in fixed-priority mode, otherwise to
  // whichever port did not win last.
  always_comb begin
    tie0    = (RR != 0) ? last_grant : 1'b1;
    gnt0    = resetn & enable & req0 & (~req1 | tie0);
    gnt1    = resetn & enable & req1 & (~req0 | ~tie0);
    xfer    = gnt0 | gnt1;
    xfer_id = gnt1;
  end

  // Address capture, tag pipeline and row return.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      rom_add    <= '0;
      s1_v       <= 1'b0;
      s1_id      <= 1'b0;
      s2_v       <= 1'b0;
      s2_id      <= 1'b0;
      data_out   <= '0;
      valid0     <= 1'b0;
      valid1     <= 1'b0;
    end else begin
      if (xfer) begin
        rom_add    <= xfer_id ? addr1 : addr0;
        last_grant <= xfer_id;
        s1_id      <= xfer_id;
      end
      s1_v   <= xfer;
      s2_v   <= s1_v;
      s2_id  <= s1_id;
      valid0 <= s2_v & ~s2_id;
      valid1 <= s2_v & s2_id;
      if (s2_v) begin
        data_out <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
module tb_font_rom_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic resetn, enable, req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic gnt0, gnt1, valid0, valid1;
  logic [AW-1:0] rom_add;
  logic [DW-1:0] rom_data, data_out;
  logic gnt0_fp, gnt1_fp, valid0_fp, valid1_fp;
  logic [AW-1:0] rom_add_fp;
  logic [DW-1:0] rom_data_fp, data_out_fp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  font_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .req0(req0), .addr0(addr0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .rom_add(rom_add), .rom_data(rom_data), .data_out(data_out),
    .valid0(valid0), .valid1(valid1));

  font_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) dut_fp (
    .clk(clk), .resetn(resetn), .enable(enable),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_fp),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_fp),
    .rom_add(rom_add_fp), .rom_data(rom_data_fp), .data_out(data_out_fp),
    .valid0(valid0_fp), .valid1(valid1_fp));

  // Font ROM contents: arbitrary but address-dependent; 0x010 -> 0x18.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h08 ^ {a[10:8], 5'b0};
  endfunction

  // Synchronous-read ROM models
  always @(posedge clk) begin
    rom_data    <= rom_fn(rom_add);
    rom_data_fp <= rom_fn(rom_add_fp);
  end

  // ---------------- reference model ----------------
  typedef struct {int due; bit id; logic [DW-1:0] d;} pend_t;
  pend_t pend[$];
  bit m_last;
  logic [AW-1:0] m_add;
  logic [DW-1:0] m_data;
  int edge_cnt = 0;
  bit m_g0, m_g1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_last = 1'b1;
    m_add  = '0;
    m_data = '0;
  endtask

  // One clock: called just after a negedge with inputs already driven.
  task automatic step();
    bit fp0, fp1, xfer, vid, pop_v, pop_id;
    logic [AW-1:0] xaddr;
    #1;
    // round-robin rule: a lone requester wins; on a tie the one that did not
    // win last time gets it
    m_g0 = 0; m_g1 = 0;
    if (resetn && enable) begin
      if (req0 && req1) begin
        if (m_last) m_g0 = 1; else m_g1 = 1;
      end else begin
        m_g0 = req0; m_g1 = req1;
      end
    end
    fp0 = resetn && enable && req0;
    fp1 = resetn && enable && req1 && !req0;
    chk("gnt0", gnt0, m_g0);
    chk("gnt1", gnt1, m_g1);
    chk("gnt0_fp", gnt0_fp, fp0);
    chk("gnt1_fp", gnt1_fp, fp1);
    xfer  = m_g0 || m_g1;
    vid   = m_g1;
    xaddr = m_g1 ? addr1 : addr0;
    @(posedge clk);
    #1;
    edge_cnt++;
    pop_v = 0; pop_id = 0;
    if (!resetn) begin
      model_reset();
    end else begin
      if (pend.size() > 0 && pend[0].due == edge_cnt) begin
        pop_v  = 1;
        pop_id = pend[0].id;
        m_data = pend[0].d;
        void'(pend.pop_front());
      end
      if (xfer) begin
        pend.push_back('{due: edge_cnt + 2, id: vid, d: rom_fn(xaddr)});
        m_add  = xaddr;
        m_last = vid;
      end
    end
    chk("rom_add", rom_add, m_add);
    chk("valid0", valid0, pop_v && !pop_id);
    chk("valid1", valid1, pop_v && pop_id);
    chk("data_out", data_out, m_data);
    @(negedge clk);
  endtask

  task automatic set_in(input bit r0, input bit r1, input bit en,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    req0 = r0; req1 = r1; enable = en; addr0 = a0; addr1 = a1;
  endtask

  typedef struct {
    bit r0, r1, en;
    logic [AW-1:0] a0, a1;
    bit g0, g1, fg0, fg1;
  } vec_t;
  vec_t vt[10];

  initial begin
    // table: starts with last winner = 0 (after the first scenario)
    vt[0] = '{1,1,1, 11'h101, 11'h202, 0,1, 1,0};
    vt[1] = '{1,1,1, 11'h103, 11'h204, 1,0, 1,0};
    vt[2] = '{1,1,1, 11'h105, 11'h206, 0,1, 1,0};
    vt[3] = '{1,1,1, 11'h107, 11'h208, 1,0, 1,0};
    vt[4] = '{0,1,0, 11'h000, 11'h3AA, 0,0, 0,0};
    vt[5] = '{0,1,1, 11'h000, 11'h3AB, 0,1, 0,1};
    vt[6] = '{1,0,1, 11'h4CC, 11'h000, 1,0, 1,0};
    vt[7] = '{0,0,1, 11'h111, 11'h222, 0,0, 0,0};
    vt[8] = '{1,1,0, 11'h333, 11'h444, 0,0, 0,0};
    vt[9] = '{0,1,1, 11'h000, 11'h5DD, 0,1, 0,1};

    resetn = 0;
    set_in(1, 1, 1, 11'h010, 11'h020);
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    step();
    chk("rst_rom_add", rom_add, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", {valid0, valid1}, 0);

    // single lookup right after reset release, addr 0x010 -> row 0x18
    resetn = 1;
    set_in(1, 0, 1, 11'h010, 11'h000);
    step();
    chk("s1_rom_add", rom_add, 11'h010);
    set_in(0, 0, 1, 11'h000, 11'h000);
    step();
    step();
    chk("s1_valid0", valid0, 1);
    chk("s1_data", data_out, 8'h18);
    step();
    chk("s1_valid0_pulse", valid0, 0);
    chk("s1_data_hold", data_out, 8'h18);

    // table-driven grant vectors (round-robin alternation, enable gating)
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].r0, vt[i].r1, vt[i].en, vt[i].a0, vt[i].a1);
      #1;
      chk($sformatf("vec%0d_g0", i), gnt0, vt[i].g0);
      chk($sformatf("vec%0d_g1", i), gnt1, vt[i].g1);
      chk($sformatf("vec%0d_fg0", i), gnt0_fp, vt[i].fg0);
      chk($sformatf("vec%0d_fg1", i), gnt1_fp, vt[i].fg1);
      step();
    end
    set_in(0, 0, 1, 0, 0);
    step(); step();

    // enable dropped the cycle after a grant
    set_in(1, 0, 1, 11'h0AB, 0);
    step();
    set_in(1, 0, 0, 11'h0AB, 0);
    step();
    chk("en_drop_valid0", valid0, 0);
    step();
    chk("en_drop_late_valid0", valid0, 1);
    chk("en_drop_data", data_out, rom_fn(11'h0AB));
    set_in(0, 0, 1, 0, 0);
    step();

    // reset one cycle after a grant discards the lookup
    set_in(1, 0, 1, 11'h123, 0);
    step();
    resetn = 0;
    set_in(0, 0, 1, 0, 0);
    model_reset();
    #1;
    chk("mid_rst_rom_add", rom_add, 0);
    step();
    step();
    chk("mid_rst_valid0", valid0, 0);
    chk("mid_rst_data", data_out, 0);
    resetn = 1;
    set_in(0, 1, 1, 0, 11'h055);
    step();
    set_in(0, 0, 1, 0, 0);
    step();
    chk("post_rst_no_stale", valid0, 0);
    step();
    chk("post_rst_valid1", valid1, 1);
    chk("post_rst_data", data_out, rom_fn(11'h055));

    // boundary addresses back to back on port 1
    set_in(0, 1, 1, 0, 11'h7FF);
    step();
    chk("bnd_add_hi", rom_add, 11'h7FF);
    set_in(0, 1, 1, 0, 11'h000);
    step();
    chk("bnd_add_lo", rom_add, 11'h000);
    set_in(0, 0, 1, 0, 0);
    step();
    chk("bnd_v1_a", valid1, 1);
    chk("bnd_d_a", data_out, rom_fn(11'h7FF));
    step();
    chk("bnd_v1_b", valid1, 1);
    chk("bnd_d_b", data_out, rom_fn(11'h000));

    // randomized traffic against the model, with occasional resets
    for (int c = 0; c < 400; c++) begin
      resetn = ($urandom_range(0, 63) != 0);
      if (!resetn) model_reset();
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) != 0, AW'($urandom), AW'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/font_rom_arbiter.md
FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the font ROM address width, {char[6:0], row[3:0]}.
REQ-002 Parameter DATA_W, default 8, SHALL set the font ROM row width in pixels.
REQ-003 Parameter RR, default 1, SHALL select the arbitration mode: 1 = round-robin, 0 = fixed priority with req0 highest.
REQ-004 clk  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 resetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 enable  in  1  SHALL permit new grants when high; lookups already in flight complete regardless.
REQ-007 req0  in  1  SHALL be the title-renderer lookup request.
REQ-008 addr0  in  ADDR_W  SHALL be the title-renderer ROM address.
REQ-009 gnt0  out  1  SHALL be the combinational grant to requester 0.
REQ-010 req1 / addr1 / gnt1 SHALL be identical to req0 / addr0 / gnt0 and serve the score renderer.
REQ-011 rom_add  out  ADDR_W  SHALL be the registered address driven to VGA_font_rom.
REQ-012 rom_data  in  DATA_W  SHALL be VGA_font_rom output, valid one cycle after rom_add changes (synchronous read).
REQ-013 data_out  out  DATA_W  SHALL be the registered font row returned to the requesters.
REQ-014 valid0 / valid1  out  1  SHALL pulse for one cycle when data_out holds the row for requester 0 / 1.

Function
REQ-015 Handshake: a transfer SHALL occur at a rising edge where req_k = 1 and gnt_k = 1; the requester holds req_k and addr_k stable until that edge.
REQ-016 At most one of gnt0 and gnt1 SHALL be high in any cycle.
REQ-017 gnt_k SHALL be 0 whenever resetn = 0, enable = 0, or req_k = 0.
REQ-018 With one request pending and enable = 1, that requester SHALL be granted in the same cycle.
REQ-019 With RR = 1 and both requests pending, the requester not recorded in last_grant SHALL be granted.
REQ-020 With RR = 0 and both requests pending, req0 SHALL be granted.
REQ-021 last_grant (1 bit) SHALL update to k on every transfer by requester k, and hold otherwise.
REQ-022 On a transfer by k at edge T: rom_add <= addr_k, and the stage-1 tag <= {valid = 1, id = k}.
REQ-023 On edge T+1: the stage-1 tag SHALL move to stage 2.
REQ-024 On edge T+2: data_out <= rom_data and valid_k = 1. Grant-to-data latency is 2 cycles.
REQ-025 Throughput SHALL be one lookup per cycle; back-to-back transfers, including alternating requesters, produce back-to-back valid pulses in transfer order.
REQ-026 With no transfer at an edge, rom_add SHALL hold its value and the stage-1 tag valid bit SHALL be cleared.
REQ-027 data_out SHALL hold its last value when no valid pulse is issued.
REQ-028 Deasserting enable SHALL NOT cancel in-flight tags; their valid pulses still arrive at T+2.
REQ-029 addr_k SHALL pass to rom_add unmodified, including at the boundary values 0x000 and 0x7FF.

Reset
REQ-030 While resetn = 0, the following SHALL hold: rom_add = 0, data_out = 0, valid0 = valid1 = 0, both tags invalid, last_grant = 1 (req0 wins the first tie).
REQ-031 Asserting resetn mid-operation SHALL immediately discard all in-flight lookups; no valid pulse is issued for them after reset is released.
REQ-032 The first grant SHALL be possible in the first cycle after resetn deasserts, given req_k = 1 and enable = 1.

Verification
REQ-033 Scenario: req0 = 1, addr0 = 0x010, ROM model returns 0x18 -> gnt0 high in cycle 0, rom_add = 0x010 after edge 1, valid0 = 1 with data_out = 0x18 after edge 3.
REQ-034 Scenario: RR = 1, req0 and req1 held high for 4 cycles -> grants alternate 0,1,0,1; valid pulses alternate in the same order with the matching rows.
REQ-035 Scenario: RR = 0, both requests held high -> gnt0 every cycle; gnt1 stays 0 until req0 drops, then gnt1 = 1 in that cycle.
REQ-036 Scenario: enable dropped the cycle after a grant -> no further gnt; the pending lookup's valid pulse still arrives 2 cycles after its grant.
REQ-037 Scenario: resetn asserted one cycle after a grant -> valid stays 0 and data_out = 0; after release, req1 is granted at once and returns the correct row.
REQ-038 Scenario: addr1 = 0x7FF then 0x000 back-to-back -> rom_add sequences 0x7FF, 0x000; two consecutive valid1 pulses.
